// File: rtl/prf_multiport_rdy.sv
`default_nettype none
// ============================================================================
//  Module   : prf_multiport_rdy
//  Brief    : Physical register file with an integrated ready (scoreboard)
//             table. It provides combinational read and ready-check ports,
//             writeback ports with a registered wakeup broadcast, rename
//             allocate ports, squash-mask recovery and a pending-tag count.
//  Options  : PRF_WR_BYPASS_EN - forward same-cycle writeback data to rd_data
//  Revision : 1.0 - initial release
// ============================================================================
module prf_multiport_rdy #(
    parameter int NUM_PREGS = 128,
    parameter int DATA_W    = 32,
    parameter int NUM_WR    = 3,
    parameter int NUM_RD    = 6,
    parameter int NUM_CHK   = 6,
    parameter int NUM_ALLOC = 3,
    localparam int PREG_W   = $clog2(NUM_PREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*PREG_W-1:0]    wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_CHK*PREG_W-1:0]   chk_addr,
    output logic [NUM_CHK-1:0]          chk_rdy,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
    input  logic                        mispredict,
    input  logic [NUM_PREGS-1:0]        squash_mask,
    output logic [NUM_WR-1:0]           wake_valid,
    output logic [NUM_WR*PREG_W-1:0]    wake_tag,
    output logic [PREG_W:0]             pending_cnt,
    output logic                        wr_conflict
);

    logic [DATA_W-1:0]    r_mem [NUM_PREGS];
    logic [NUM_PREGS-1:0] r_rdy;
    logic [NUM_PREGS-1:0] w_rdy_next;
    logic [PREG_W:0]      w_pend_next;
    logic [NUM_WR-1:0]    w_wr_live;
    logic                 w_conflict;

    // Writes to tag 0 are dropped everywhere, so qualify each port once here.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            w_wr_live[w] = wr_en[w] && (wr_addr[w*PREG_W +: PREG_W] != '0);
        end
    end

    // Next ready table: alloc clears (skipped on mispredict), squash sets,
    // writeback sets last so it overrides a same-cycle alloc.
    always_comb begin
        w_rdy_next = r_rdy;
        if (mispredict) begin
            w_rdy_next = r_rdy | squash_mask;
        end else begin
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_en[a]) begin
                    w_rdy_next[alloc_addr[a*PREG_W +: PREG_W]] = 1'b0;
                end
            end
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (w_wr_live[w]) begin
                w_rdy_next[wr_addr[w*PREG_W +: PREG_W]] = 1'b1;
            end
        end
        w_rdy_next[0] = 1'b1;
    end

    // Count not-ready tags in the next-state table; tag 0 can never be pending.
    always_comb begin
        w_pend_next = '0;
        for (int k = 1; k < NUM_PREGS; k++) begin
            w_pend_next = w_pend_next + {{PREG_W{1'b0}}, !w_rdy_next[k]};
        end
    end

    // Flag any pair of live write ports that target the same tag.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (w_wr_live[i] && w_wr_live[j] &&
                    (wr_addr[i*PREG_W +: PREG_W] == wr_addr[j*PREG_W +: PREG_W])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Data array: ascending port loop makes the highest index win a multi-hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_PREGS; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_live[w]) begin
                    r_mem[wr_addr[w*PREG_W +: PREG_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Ready table, wakeup broadcast, pending count and conflict pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdy       <= '1;
            wake_valid  <= '0;
            wake_tag    <= '0;
            pending_cnt <= '0;
            wr_conflict <= 1'b0;
        end else begin
            r_rdy       <= w_rdy_next;
            wake_valid  <= w_wr_live;
            pending_cnt <= w_pend_next;
            wr_conflict <= w_conflict;
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_live[w]) begin
                    wake_tag[w*PREG_W +: PREG_W] <= wr_addr[w*PREG_W +: PREG_W];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [PREG_W-1:0] w_tag;
        logic [DATA_W-1:0] w_val;
        assign w_tag = rd_addr[r*PREG_W +: PREG_W];

        // Stored value (tag 0 reads zero), optionally overridden by writeback.
        always_comb begin
            w_val = (w_tag == '0) ? '0 : r_mem[w_tag];
`ifdef PRF_WR_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_live[w] && (wr_addr[w*PREG_W +: PREG_W] == w_tag)) begin
                    w_val = wr_data[w*DATA_W +: DATA_W];
                end
            end
`else
`endif
        end

        assign rd_data[r*DATA_W +: DATA_W] = w_val;
    end

    for (genvar c = 0; c < NUM_CHK; c++) begin : g_chk
        logic [PREG_W-1:0] w_tag;
        logic              w_rdy;
        assign w_tag = chk_addr[c*PREG_W +: PREG_W];

        // Stored ready bit, woken early by any same-cycle writeback to the tag.
        always_comb begin
            w_rdy = r_rdy[w_tag];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*PREG_W +: PREG_W] == w_tag)) begin
                    w_rdy = 1'b1;
                end
            end
        end

        assign chk_rdy[c] = w_rdy;
    end

endmodule
`default_nettype wire
